// File: rtl/buck_ctrl_pkg.sv
// Shared types and widths for the buck PWM controller.
package buck_ctrl_pkg;

  localparam int unsigned DutyW = 8;
  localparam int unsigned VoltW = 16;
  localparam int unsigned CntW  = 8;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StSoftstart = 2'd1,
    StRun       = 2'd2,
    StFault     = 2'd3
  } buck_state_e;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter (0..PERIOD-1) with a registered period-start strobe.
module pwm_period_counter
  import buck_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD = 200
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [CntW-1:0] cnt_o,
  output logic            wrap_o,
  output logic            sync_o
);

  localparam logic [CntW-1:0] Last = CntW'(PERIOD - 1);

  logic [CntW-1:0] cnt_q;
  logic            sync_q;

  assign wrap_o = (cnt_q == Last);
  assign cnt_o  = cnt_q;
  assign sync_o = sync_q;

  // Count and wrap; sync marks the first cycle of the new period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= wrap_o ? '0 : cnt_q + 1'b1;
      sync_q <= wrap_o;
    end
  end

endmodule

// File: rtl/buck_pwm_controller.sv
// PWM sequencer for the buck converter model: soft-start, duty tracking, period strobe.
// Optional over-voltage protection is compiled in when BUCK_OVP_EN is defined.
module buck_pwm_controller
  import buck_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD    = 200,
  parameter int unsigned DUTY_MAX  = 180,
  parameter int unsigned RAMP_STEP = 4,
  parameter int unsigned OVP_CNT   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [DutyW-1:0] duty_target_i,
  input  logic [VoltW-1:0] v_fb_i,
  input  logic [VoltW-1:0] ovp_limit_i,
  output logic             sw_o,
  output logic             sync_o,
  output logic [DutyW-1:0] duty_o,
  output logic [1:0]       state_o,
  output logic             fault_o
);

  localparam logic [DutyW-1:0] DutyMax  = DutyW'(DUTY_MAX);
  localparam logic [DutyW-1:0] RampStep = DutyW'(RAMP_STEP);

  buck_state_e      state_q, state_d;
  logic [DutyW-1:0] duty_q, duty_d;
  logic             sw_q, sw_d;
  logic [CntW-1:0]  cnt;
  logic             wrap;
  logic             ovp_trip;
  logic [DutyW-1:0] target, gap, duty_slewed;

  pwm_period_counter #(
    .PERIOD (PERIOD)
  ) u_period (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cnt_o  (cnt),
    .wrap_o (wrap),
    .sync_o (sync_o)
  );

  // Clamped target and the duty value one slew step closer to it.
  always_comb begin
    target = (duty_target_i > DutyMax) ? DutyMax : duty_target_i;
    gap    = target - duty_q;
    if (target > duty_q) begin
      duty_slewed = duty_q + ((gap > RampStep) ? RampStep : gap);
    end else begin
      duty_slewed = target;
    end
  end

`ifdef BUCK_OVP_EN
  localparam logic [7:0] OvpLast = 8'(OVP_CNT - 1);

  logic [7:0] ovp_cnt_q, ovp_cnt_d;

  // Count consecutive over-limit cycles while switching; trip on reaching OVP_CNT.
  always_comb begin
    ovp_cnt_d = '0;
    ovp_trip  = 1'b0;
    if ((state_q == StSoftstart || state_q == StRun) && (v_fb_i > ovp_limit_i)) begin
      ovp_cnt_d = ovp_cnt_q + 8'd1;
      ovp_trip  = (ovp_cnt_q == OvpLast);
    end
  end

  // Over-voltage counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) ovp_cnt_q <= '0;
    else       ovp_cnt_q <= ovp_cnt_d;
  end

  assign fault_o = (state_q == StFault);
`else
  logic unused_ovp;
  assign unused_ovp = ^{v_fb_i, ovp_limit_i, 8'(OVP_CNT)};
  assign ovp_trip   = 1'b0;
  assign fault_o    = 1'b0;
`endif

  // Next state and duty; duty only moves at the period wrap, fault beats enable drop.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    unique case (state_q)
      StIdle: begin
        duty_d = '0;
        if (enable_i) state_d = StSoftstart;
      end
      StSoftstart, StRun: begin
        if (ovp_trip) begin
          state_d = StFault;
          duty_d  = '0;
        end else if (!enable_i) begin
          state_d = StIdle;
          duty_d  = '0;
        end else if (wrap) begin
          duty_d = duty_slewed;
          if (state_q == StSoftstart && duty_slewed == target) state_d = StRun;
        end
      end
      StFault: begin
        duty_d = '0;
        if (!enable_i) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        duty_d  = '0;
      end
    endcase
    // Gate is killed in the same cycle the FSM leaves a switching state.
    sw_d = ((state_d == StSoftstart) || (state_d == StRun)) && (cnt < duty_q);
  end

  // State, duty and gate registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      duty_q  <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      sw_q    <= sw_d;
    end
  end

  assign sw_o    = sw_q;
  assign duty_o  = duty_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_buck_pwm_controller.sv
// Self-checking bench for buck_pwm_controller with a behavioural cycle model.
// Honours BUCK_OVP_EN the same way as the design.
module tb_buck_pwm_controller;

  localparam int Period   = 200;
  localparam int DutyMax  = 180;
  localparam int RampStep = 4;
  localparam int OvpCnt   = 8;
`ifdef BUCK_OVP_EN
  localparam bit OvpEn = 1'b1;
`else
  localparam bit OvpEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  duty_target;
  logic [15:0] v_fb;
  logic [15:0] ovp_limit;
  logic        sw;
  logic        sync;
  logic [7:0]  duty;
  logic [1:0]  state;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: values the outputs should hold in the current cycle.
  int m_cnt, m_duty, m_state, m_ovp, m_sw, m_sync;

  always #5 clk = ~clk;

  buck_pwm_controller dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .duty_target_i (duty_target),
    .v_fb_i        (v_fb),
    .ovp_limit_i   (ovp_limit),
    .sw_o          (sw),
    .sync_o        (sync),
    .duty_o        (duty),
    .state_o       (state),
    .fault_o       (fault)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int  t, nstate, nduty;
    bit  wrap, active, trip;
    if (rst) begin
      m_cnt = 0; m_duty = 0; m_state = 0; m_ovp = 0; m_sw = 0; m_sync = 0;
      return;
    end
    t      = min2(int'(duty_target), DutyMax);
    wrap   = (m_cnt == Period - 1);
    active = (m_state == 1) || (m_state == 2);
    trip   = 1'b0;
    if (OvpEn && active && (v_fb > ovp_limit)) begin
      m_ovp++;
      trip = (m_ovp >= OvpCnt);
    end else begin
      m_ovp = 0;
    end
    nstate = m_state;
    nduty  = m_duty;
    if (m_state == 0) begin
      nduty = 0;
      if (enable) nstate = 1;
    end else if (m_state == 3) begin
      nduty = 0;
      if (!enable) nstate = 0;
    end else if (trip) begin
      nstate = 3; nduty = 0;
    end else if (!enable) begin
      nstate = 0; nduty = 0;
    end else if (wrap) begin
      nduty = (t > m_duty) ? m_duty + min2(RampStep, t - m_duty) : t;
      if (m_state == 1 && nduty == t) nstate = 2;
    end
    m_sw    = ((nstate == 1 || nstate == 2) && (m_cnt < m_duty)) ? 1 : 0;
    m_sync  = wrap ? 1 : 0;
    m_cnt   = wrap ? 0 : m_cnt + 1;
    m_duty  = nduty;
    m_state = nstate;
  endtask

  // Clock n cycles, comparing every output against the model on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_eq("sw", int'(sw), m_sw);
      check_eq("sync", int'(sync), m_sync);
      check_eq("duty", int'(duty), m_duty);
      check_eq("state", int'(state), m_state);
      check_eq("fault", int'(fault), (m_state == 3) ? 1 : 0);
    end
  endtask

  task automatic step_to_cnt(input int c);
    for (int i = 0; i < 2 * Period && m_cnt != c; i++) step(1);
  endtask

  initial begin
    int highs, pulses, burst;

    rst = 1'b1; enable = 1'b0; duty_target = 8'd0; v_fb = 16'd0; ovp_limit = 16'd1000;
    m_cnt = 0; m_duty = 0; m_state = 0; m_ovp = 0; m_sw = 0; m_sync = 0;
    step(3);
    check_eq("rst_sw", int'(sw), 0);
    check_eq("rst_duty", int'(duty), 0);
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_sync", int'(sync), 0);
    check_eq("rst_fault", int'(fault), 0);

    // Soft-start to 100; without OVP the feedback is pinned at full scale.
    rst = 1'b0; enable = 1'b1; duty_target = 8'd100;
    v_fb = OvpEn ? 16'd0 : 16'hFFFF;
    step(26 * Period);
    check_eq("ss_duty", int'(duty), 100);
    check_eq("ss_state", int'(state), 2);
    highs = 0;
    for (int i = 0; i < Period; i++) begin
      step(1);
      highs += int'(sw);
    end
    check_eq("sw_high_100", highs, 100);
    v_fb = 16'd0;

    // Raise past the clamp, then drop: decrease lands at the next wrap only.
    duty_target = 8'd250;
    step(21 * Period);
    check_eq("clamp_duty", int'(duty), 180);
    check_eq("clamp_state", int'(state), 2);
    step_to_cnt(100);
    duty_target = 8'd50;
    step(50);
    check_eq("hold_mid", int'(duty), 180);
    step(100);
    check_eq("drop_duty", int'(duty), 50);

    // Enable falls mid-period.
    step_to_cnt(50);
    enable = 1'b0;
    step(1);
    check_eq("off_state", int'(state), 0);
    check_eq("off_duty", int'(duty), 0);
    check_eq("off_sw", int'(sw), 0);
    pulses = 0;
    for (int i = 0; i < 2 * Period; i++) begin
      step(1);
      pulses += int'(sync);
    end
    check_eq("idle_sync", pulses, 2);

    // Over-voltage: 7 cycles over is tolerated, 8 trips (OVP builds only).
    enable = 1'b1; duty_target = 8'd100;
    step(300);
    v_fb = 16'd1001; step(7);
    v_fb = 16'd999;  step(1);
    check_eq("ovp7_fault", int'(fault), 0);
    v_fb = 16'd1001; step(8);
    check_eq("ovp8_fault", int'(fault), OvpEn ? 1 : 0);
    check_eq("ovp8_sw", int'(sw), OvpEn ? 0 : m_sw);
    v_fb = 16'd0; step(5);
    enable = 1'b0; step(1);
    check_eq("ovp_clr_state", int'(state), 0);
    check_eq("ovp_clr_fault", int'(fault), 0);

    // Reset in the middle of soft-start.
    enable = 1'b1; duty_target = 8'd100;
    step(700);
    check_eq("pre_rst_state", int'(state), 1);
    rst = 1'b1; step(1);
    check_eq("mid_rst_duty", int'(duty), 0);
    check_eq("mid_rst_state", int'(state), 0);
    check_eq("mid_rst_sw", int'(sw), 0);
    rst = 1'b0;

    // Randomised run against the model.
    burst = 0; duty_target = 8'd90;
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 399) == 0) duty_target = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2999) == 0) enable = ~enable;
      if ($urandom_range(0, 499) == 0) burst = $urandom_range(1, 12);
      if (burst > 0) begin
        v_fb = 16'(1001 + $urandom_range(0, 50));
        burst--;
      end else begin
        v_fb = 16'($urandom_range(0, 1000));
      end
      rst = ($urandom_range(0, 9999) == 0);
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
